// File: rtl/fpu_issue_ctrl_if.sv
// FPU issue bundle: core request, unit fan-out/fan-in, writeback stream, status.
// Latency: bundle only; req_ready/unit_* are same-cycle functions of req_*.
// Backpressure: the core holds req_* stable until req_valid & req_ready.
interface fpu_issue_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [4:0]   req_rd;
  logic [4:0]   req_rs1;
  logic [4:0]   req_rs2;
  logic [31:0]  req_x1;
  logic [31:0]  req_x2;
  logic [3:0]   unit_valid;
  logic [31:0]  unit_x1;
  logic [31:0]  unit_x2;
  logic [127:0] unit_y;
  logic [3:0]   unit_out_valid;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic [31:0]  pending;
  logic         err;

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_x1, req_x2,
    input  unit_y, unit_out_valid,
    output req_ready, unit_valid, unit_x1, unit_x2,
    output wb_valid, wb_rd, wb_data, pending, err
  );

  // Core + FPU units side.
  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_x1, req_x2,
    output unit_y, unit_out_valid,
    input  req_ready, unit_valid, unit_x1, unit_x2,
    input  wb_valid, wb_rd, wb_data, pending, err
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issues FP ops to fixed-latency units, reserves writeback slots, keeps a RAW/WAW scoreboard.
// Latency: unit_valid same cycle as accept; wb_* registered, visible L(op)+1 cycles after accept.
// Backpressure: req_ready drops on a pending rd/rs1/rs2 or a writeback-slot collision.
// Optional checker: define FPU_ISSUE_CHECK_EN for the sticky unit-protocol err flag.
module fpu_issue_ctrl #(
  parameter int LAT_CMP = 1,
  parameter int LAT_ADD = 3,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 8,
  parameter int MAX_LAT = 8   // must be >= every LAT_*
) (
  input logic             sys_clk,
  input logic             rstn,
  fpu_issue_ctrl_if.slave bus
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [1:0] op;
  } res_t;

  // res[i] describes the instruction whose result appears at the units i-1 cycles from now.
  res_t        res [1:MAX_LAT];
  logic [31:0] pend_q;
  logic [31:0] pend_d;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  int          req_lat;
  logic        slot_busy;
  logic        hazard;
  logic        ready;
  logic        accept;

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'd0:    return LAT_CMP;
      2'd1:    return LAT_ADD;
      2'd2:    return LAT_MUL;
      default: return LAT_DIV;
    endcase
  endfunction

  // Issue decision: the slot checked is L+1 because it shifts into L on the accept edge.
  always_comb begin
    req_lat   = lat_of(bus.req_op);
    slot_busy = 1'b0;
    for (int i = 1; i <= MAX_LAT; i++) begin
      if (i == req_lat + 1) slot_busy = res[i].v;
    end
    hazard = pend_q[bus.req_rd] | pend_q[bus.req_rs1] | pend_q[bus.req_rs2];
    ready  = rstn & ~hazard & ~slot_busy;
    accept = bus.req_valid & ready;
  end

  assign bus.req_ready  = ready;
  assign bus.unit_valid = accept ? (4'b0001 << bus.req_op) : 4'b0000;
  assign bus.unit_x1    = bus.req_x1;
  assign bus.unit_x2    = bus.req_x2;

  // Reservation shift register; the accept write lands after the shift and wins slot L.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      for (int i = 1; i <= MAX_LAT; i++) res[i] <= '0;
    end else begin
      for (int i = 1; i < MAX_LAT; i++) res[i] <= res[i+1];
      res[MAX_LAT] <= '0;
      if (accept) begin
        for (int i = 1; i <= MAX_LAT; i++) begin
          if (i == req_lat) res[i] <= '{v: 1'b1, rd: bus.req_rd, op: bus.req_op};
        end
      end
    end
  end

  // Writeback register: capture the unit named by res[1]; rd/data hold when idle.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= res[1].v;
      if (res[1].v) begin
        wb_rd_q   <= res[1].rd;
        wb_data_q <= bus.unit_y[{res[1].op, 5'd0} +: 32];
      end
    end
  end

  // Scoreboard next state: clear the retiring rd first, then set the newly issued rd.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid_q) pend_d[wb_rd_q] = 1'b0;
    if (accept)     pend_d[bus.req_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge sys_clk) begin
    if (!rstn) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign bus.pending  = pend_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;

`ifdef FPU_ISSUE_CHECK_EN
  logic [3:0] exp_ov;
  logic       viol;
  logic       err_q;

  // Exactly the reserved unit may raise out_valid; a missing, stray or extra bit all differ.
  always_comb begin
    exp_ov = res[1].v ? (4'b0001 << res[1].op) : 4'b0000;
    viol   = (bus.unit_out_valid != exp_ov);
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge sys_clk) begin
    if (!rstn)     err_q <= 1'b0;
    else if (viol) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  logic unused_out_valid;
  assign unused_out_valid = ^bus.unit_out_valid;
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed issue sequences, fixed-latency unit models,
// and a transaction-level model of expected handshake, writeback and scoreboard.
module tb_fpu_issue_ctrl;
  logic sys_clk = 1'b0;
  logic rstn;
  always #5 sys_clk = ~sys_clk;

  fpu_issue_ctrl_if bus();
  fpu_issue_ctrl dut (.sys_clk(sys_clk), .rstn(rstn), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit model_on = 1'b0;
  int withhold_issue = -1;
  int wb_seen [32] = '{default: -1};

  typedef struct { int due; int op; int issue; logic [31:0] data; } unit_job_t;
  typedef struct { int rd; int op; int issue; logic [31:0] data; } flight_t;
  unit_job_t jobs[$];
  flight_t   flight[$];
  bit        err_set = 1'b0;

  function automatic int lat(input int op);
    case (op)
      0:       return 1;
      1:       return 3;
      2:       return 2;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] unit_fn(input int op, input logic [31:0] a, input logic [31:0] b);
    if (op == 0) return 32'hFFFF_FFFF;
    return a + b + 32'(op);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // FPU unit models: respond to unit_valid after their fixed latency.
  always @(posedge sys_clk) begin
    unit_job_t jb;
    unit_job_t keep[$];
    for (int k = 0; k < 4; k++) begin
      if (bus.unit_valid[k] === 1'b1) begin
        jb.due   = cyc + lat(k);
        jb.op    = k;
        jb.issue = cyc;
        jb.data  = unit_fn(k, bus.unit_x1, bus.unit_x2);
        jobs.push_back(jb);
      end
    end
    cyc = cyc + 1;
    #1;
    bus.unit_out_valid = '0;
    bus.unit_y         = '0;
    keep = {};
    foreach (jobs[j]) begin
      if (jobs[j].due == cyc) begin
        if (jobs[j].issue != withhold_issue) begin
          bus.unit_out_valid[jobs[j].op]     = 1'b1;
          bus.unit_y[jobs[j].op * 32 +: 32] = jobs[j].data;
        end
      end else if (jobs[j].due > cyc) begin
        keep.push_back(jobs[j]);
      end
    end
    jobs = keep;
  end

  // Compare process: expected outputs from the in-flight instruction list.
  always @(negedge sys_clk) begin
    if (model_on) begin
      logic [31:0] e_pend;
      logic        e_rdy, e_wbv, coll;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic [3:0]  e_uv, e_ov;
      flight_t     keep[$];
      flight_t     nf;
      int          rop;
      rop = int'(bus.req_op);
      e_pend = '0; e_wbv = 1'b0; e_rd = '0; e_data = '0; e_ov = '0; coll = 1'b0;
      foreach (flight[j]) begin
        e_pend[flight[j].rd] = 1'b1;
        if (flight[j].issue + lat(flight[j].op) + 1 == cyc) begin
          e_wbv = 1'b1; e_rd = 5'(flight[j].rd); e_data = flight[j].data;
        end
        if (flight[j].issue + lat(flight[j].op) == cyc) e_ov[flight[j].op] = 1'b1;
        if (flight[j].issue + lat(flight[j].op) == cyc + lat(rop)) coll = 1'b1;
      end
      e_rdy = rstn && !e_pend[bus.req_rd] && !e_pend[bus.req_rs1] && !e_pend[bus.req_rs2] && !coll;
      e_uv  = (bus.req_valid && e_rdy) ? (4'b0001 << bus.req_op) : 4'b0000;

      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, e_rdy});
      chk("unit_valid", {28'd0, bus.unit_valid}, {28'd0, e_uv});
      chk("unit_x1", bus.unit_x1, bus.req_x1);
      chk("unit_x2", bus.unit_x2, bus.req_x2);
      chk("wb_valid", {31'd0, bus.wb_valid}, {31'd0, e_wbv});
      if (e_wbv) begin
        chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e_rd});
        chk("wb_data", bus.wb_data, e_data);
      end
      chk("pending", bus.pending, e_pend);
`ifdef FPU_ISSUE_CHECK_EN
      chk("err", {31'd0, bus.err}, {31'd0, err_set});
`else
      chk("err", {31'd0, bus.err}, 32'd0);
`endif
      if (bus.wb_valid === 1'b1) wb_seen[bus.wb_rd] = cyc;

      if (!rstn) begin
        flight  = {};
        err_set = 1'b0;
      end else begin
        if (bus.unit_out_valid !== e_ov) err_set = 1'b1;
        keep = {};
        foreach (flight[j]) begin
          nf = flight[j];
          if (nf.issue + lat(nf.op) == cyc && bus.unit_out_valid[nf.op] !== 1'b1) nf.data = '0;
          if (nf.issue + lat(nf.op) + 1 > cyc) keep.push_back(nf);
        end
        if (bus.req_valid && e_rdy) begin
          nf.rd = int'(bus.req_rd); nf.op = rop; nf.issue = cyc;
          nf.data = unit_fn(rop, bus.req_x1, bus.req_x2);
          keep.push_back(nf);
        end
        flight = keep;
      end
    end
  end

  task automatic nxt();
    @(posedge sys_clk); #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) nxt();
    @(negedge sys_clk);
  endtask

  // Offer one instruction at the start of a cycle and hold it until accepted.
  task automatic send(input int op, input int rd, input int rs1, input int rs2,
                      input logic [31:0] x1, input logic [31:0] x2,
                      output int acc, output logic [3:0] uv);
    bus.req_valid = 1'b1; bus.req_op = 2'(op); bus.req_rd = 5'(rd);
    bus.req_rs1 = 5'(rs1); bus.req_rs2 = 5'(rs2); bus.req_x1 = x1; bus.req_x2 = x2;
    acc = -1; uv = '0;
    for (int n = 0; n < 40 && acc < 0; n++) begin
      @(negedge sys_clk);
      if (bus.req_ready === 1'b1) begin acc = cyc; uv = bus.unit_valid; end
      nxt();
    end
    bus.req_valid = 1'b0; bus.req_rd = 5'd31; bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0;
    n_cmp++;
    if (acc < 0) begin
      n_bad++;
      $display("FAIL send_timeout rd=%0d: got no accept in 40 cycles, want accept", rd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;
    int acc [8];
    logic [3:0] uv;
    rstn = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_rd = 5'd31;
    bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0; bus.req_x1 = '0; bus.req_x2 = '0;
    nxt();
    bus.req_valid = 1'b1;
    @(negedge sys_clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_unit_valid", {28'd0, bus.unit_valid}, 32'd0);
    nxt();
    bus.req_valid = 1'b0;
    nxt();
    rstn = 1'b1; model_on = 1'b1;
    @(negedge sys_clk);
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_pending", bus.pending, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);

    // Single compare instruction.
    nxt();
    send(0, 5, 0, 0, 32'h3F80_0000, 32'h4000_0000, a, uv);
    chk("cmp_unit_valid", {28'd0, uv}, 32'h1);
    goto(a + 1);
    chk("cmp_pend_t1", {31'd0, bus.pending[5]}, 32'd1);
    goto(a + 2);
    chk("cmp_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    chk("cmp_wb_rd", {27'd0, bus.wb_rd}, 32'd5);
    chk("cmp_wb_data", bus.wb_data, 32'hFFFF_FFFF);
    chk("cmp_pend_t2", {31'd0, bus.pending[5]}, 32'd1);
    goto(a + 3);
    chk("cmp_pend_t3", {31'd0, bus.pending[5]}, 32'd0);

    // RAW stall behind a divide.
    nxt();
    send(3, 1, 0, 0, 32'h4040_0000, 32'h3F80_0000, a, uv);
    chk("div_unit_valid", {28'd0, uv}, 32'h8);
    send(0, 2, 1, 0, 32'h1111_1111, 32'h2222_2222, b, uv);
    chk("raw_accept_cycle", b, a + 10);
    goto(a + 14);
    chk("raw_wb_cycle_rd1", wb_seen[1], a + 9);
    chk("raw_wb_cycle_rd2", wb_seen[2], a + 12);

    // Writeback slot collision: mul after add.
    nxt();
    send(1, 3, 0, 0, 32'h0000_0010, 32'h0000_0020, a, uv);
    send(2, 4, 0, 0, 32'h0000_0100, 32'h0000_0200, b, uv);
    chk("slot_accept_cycle", b, a + 2);
    chk("mul_unit_valid", {28'd0, uv}, 32'h4);
    goto(a + 8);
    chk("slot_wb_cycle_rd3", wb_seen[3], a + 4);
    chk("slot_wb_cycle_rd4", wb_seen[4], a + 5);

    // Eight back-to-back compares.
    nxt();
    for (int i = 0; i < 8; i++)
      send(0, 8 + i, 0, 0, 32'(i), 32'(i * 3), acc[i], uv);
    for (int i = 1; i < 8; i++) chk("b2b_accept_cycle", acc[i], acc[0] + i);
    goto(acc[0] + 12);
    for (int i = 0; i < 8; i++) chk("b2b_wb_cycle", wb_seen[8 + i], acc[0] + 2 + i);

`ifdef FPU_ISSUE_CHECK_EN
    // Withheld out_valid raises the sticky error.
    nxt();
    withhold_issue = cyc;
    send(0, 6, 0, 0, 32'h1, 32'h2, a, uv);
    chk("chk_accept_cycle", a, withhold_issue);
    goto(a + 1);
    chk("chk_err_t1", {31'd0, bus.err}, 32'd0);
    goto(a + 2);
    chk("chk_err_t2", {31'd0, bus.err}, 32'd1);
    chk("chk_wb_still", {31'd0, bus.wb_valid}, 32'd1);
    goto(a + 5);
    chk("chk_err_sticky", {31'd0, bus.err}, 32'd1);
    nxt();
    rstn = 1'b0;
    nxt();
    rstn = 1'b1;
    @(negedge sys_clk);
    chk("chk_err_cleared", {31'd0, bus.err}, 32'd0);
`endif

    // Reset with a divide in flight.
    nxt();
    send(3, 20, 0, 0, 32'h4080_0000, 32'h4000_0000, a, uv);
    while (cyc < a + 3) nxt();
    rstn = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_rd = 5'd21;
    @(negedge sys_clk);
    chk("midrst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("midrst_unit_valid", {28'd0, bus.unit_valid}, 32'd0);
    nxt();
    rstn = 1'b1;
    bus.req_valid = 1'b0; bus.req_rd = 5'd31;
    @(negedge sys_clk);
    chk("midrst_pending", bus.pending, 32'd0);
    chk("midrst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    goto(a + 12);
    chk("midrst_no_late_wb", wb_seen[20], -1);

    goto(cyc + 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
